// File: rtl/scu_ctrl_pkg.sv
// scu_ctrl_pkg: shared definitions for the stall/flush control unit.
//   STOP / NOSTOP : stall request / stall output polarity.
//   scu_state_e   : FSM encoding (RUN = 2'b00, HOLD = 2'b01, FLUSH = 2'b10; 2'b11 unused).
//   FlushCntW     : width of the flush-length counter (FLUSH_LEN range 1..15).
// Optional feature macro used by the block: SCU_PERF_EN (stall performance counter).
package scu_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  typedef enum logic [1:0] {
    ScuRun   = 2'b00,
    ScuHold  = 2'b01,
    ScuFlush = 2'b10
  } scu_state_e;

  localparam int unsigned FlushCntW = 4;

endpackage

// File: rtl/scu_ctrl_if.sv
// scu_ctrl_if: pipeline <-> stall control unit signal bundle.
//   stallreq  [STAGES] : per-stage stall requests (pipeline -> scu)
//   i_stall / d_stall  : instruction / data AXI transfer outstanding
//   flush_req          : one-cycle flush request (exception / eret)
//   stall     [STAGES] : per-stage hold (scu -> pipeline)
//   flush              : registered flush to all pipeline registers
//   scu_state [2]      : FSM state for debug
//   perf_clr, stall_cycles [CNT_W] : only when SCU_PERF_EN is defined
// Modports: master = pipeline side, slave = scu_ctrl.
interface scu_ctrl_if #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [STAGES-1:0] stallreq;
  logic              i_stall;
  logic              d_stall;
  logic              flush_req;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic [1:0]        scu_state;
`ifdef SCU_PERF_EN
  logic              perf_clr;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output stallreq, i_stall, d_stall, flush_req, perf_clr,
    input  stall, flush, scu_state, stall_cycles
  );
  modport slave (
    input  stallreq, i_stall, d_stall, flush_req, perf_clr,
    output stall, flush, scu_state, stall_cycles
  );
`else
  modport master (
    output stallreq, i_stall, d_stall, flush_req,
    input  stall, flush, scu_state
  );
  modport slave (
    input  stallreq, i_stall, d_stall, flush_req,
    output stall, flush, scu_state
  );
`endif
endinterface

// File: rtl/scu_ctrl_stall_mask_gen.sv
// scu_ctrl_stall_mask_gen (stall_mask_gen): priority encoder plus thermometer expansion.
//   stallreq_i [STAGES] : per-stage stall requests
//   mask_o     [STAGES] : bits 0..msb(stallreq_i) set, all zero when no request
module scu_ctrl_stall_mask_gen
  import scu_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 5
) (
  input  logic [STAGES-1:0] stallreq_i,
  output logic [STAGES-1:0] mask_o
);

  logic hit;

  // Scan from the top stage down: once the highest request is found, every
  // lower stage must also hold so the bubble does not get overwritten.
  always_comb begin
    mask_o = '0;
    hit    = 1'b0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      if (stallreq_i[i] == STOP) hit = 1'b1;
      mask_o[i] = hit ? STOP : NOSTOP;
    end
  end

endmodule

// File: rtl/scu_ctrl.sv
// scu_ctrl: stall/flush control unit for the pipelined MIPS core.
//   cpu_clk_50M : core clock, rising edge
//   cpu_rst_n   : asynchronous active-low reset
//   bus         : scu_ctrl_if.slave (stall requests, bus stalls, flush_req in;
//                 stall, flush, scu_state out; perf_clr / stall_cycles with SCU_PERF_EN)
// Macro SCU_PERF_EN adds a saturating count of cycles with any stage stalled.
module scu_ctrl
  import scu_ctrl_pkg::*;
#(
  parameter int unsigned STAGES        = 5,
  parameter int unsigned I_STALL_DEPTH = 2,
  parameter int unsigned FLUSH_LEN     = 2,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst_n,
  scu_ctrl_if.slave  bus
);

  localparam logic [STAGES-1:0] IStallMask =
    STAGES'((64'd1 << I_STALL_DEPTH) - 64'd1);
  localparam logic [FlushCntW-1:0] CntLoad = FlushCntW'(FLUSH_LEN - 1);

  scu_state_e           state_q, state_d;
  logic [FlushCntW-1:0] cnt_q, cnt_d;
  logic                 flush_q, flush_d;
  logic [STAGES-1:0]    req_mask;
  logic [STAGES-1:0]    stall;
  logic                 bus_busy;

  scu_ctrl_stall_mask_gen #(
    .STAGES (STAGES)
  ) u_mask (
    .stallreq_i (bus.stallreq),
    .mask_o     (req_mask)
  );

  assign bus_busy = bus.i_stall | bus.d_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ScuRun: begin
        if (bus.flush_req) begin
          if (bus_busy) begin
            state_d = ScuHold;
          end else begin
            state_d = ScuFlush;
            cnt_d   = CntLoad;
          end
        end
      end
      // Further flush_req pulses in HOLD/FLUSH merge into the pending flush.
      ScuHold: begin
        if (!bus_busy) begin
          state_d = ScuFlush;
          cnt_d   = CntLoad;
        end
      end
      ScuFlush: begin
        if (cnt_q == '0) state_d = ScuRun;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ScuRun;
    endcase
    flush_d = (state_d == ScuFlush);
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= ScuRun;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  // Reset gates stall directly so the pipeline is released while reset is low,
  // regardless of what the request inputs are doing.
  always_comb begin
    stall = '0;
    if (cpu_rst_n) begin
      case (state_q)
        ScuRun:  stall = req_mask | (bus.i_stall ? IStallMask : '0) | (bus.d_stall ? '1 : '0);
        ScuHold: stall = '1;
        default: stall = '0;
      endcase
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush_q;
  assign bus.scu_state = state_q;

`ifdef SCU_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (bus.perf_clr) begin
      stall_cycles_d = '0;
    end else if ((stall != '0) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) stall_cycles_q <= '0;
    else            stall_cycles_q <= stall_cycles_d;
  end

  assign bus.stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_scu_ctrl.sv
// tb_scu_ctrl: scoreboard bench for scu_ctrl (STAGES=5, I_STALL_DEPTH=2, FLUSH_LEN=2, CNT_W=4).
// The driver applies inputs on the falling edge and pushes the expected outputs for that
// cycle; the monitor pops and compares shortly after. Define SCU_PERF_EN for the counter.
module tb_scu_ctrl;

  localparam int Stages    = 5;
  localparam int IDepth    = 2;
  localparam int FlushLen  = 2;
  localparam int CntMax    = 15;

  typedef struct packed {
    logic [4:0] stall;
    logic       flush;
    logic [1:0] st;
    logic [3:0] cyc;
  } exp_t;

  logic clk;
  logic cpu_rst_n;

  scu_ctrl_if #(.STAGES(Stages), .CNT_W(4)) bus ();

  scu_ctrl #(
    .STAGES        (Stages),
    .I_STALL_DEPTH (IDepth),
    .FLUSH_LEN     (FlushLen),
    .CNT_W         (4)
  ) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (cpu_rst_n),
    .bus         (bus)
  );

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: remaining flush cycles, whether a flush waits for the bus,
  // and the number of stalled cycles seen so far.
  int m_flush_left = 0;
  bit m_pending    = 0;
  int m_cyc        = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic step(input logic [4:0] sr, input logic is, input logic ds, input logic fr,
                      input logic clr, input logic rst);
    exp_t e;
    int   msk;
    @(negedge clk);
    bus.stallreq  = sr;
    bus.i_stall   = is;
    bus.d_stall   = ds;
    bus.flush_req = fr;
`ifdef SCU_PERF_EN
    bus.perf_clr  = clr;
`endif
    cpu_rst_n     = rst;
    e = '0;
    if (!rst) begin
      m_flush_left = 0;
      m_pending    = 0;
      m_cyc        = 0;
    end else begin
      msk = 0;
      if (sr != 0) msk = (1 << $clog2(int'(sr) + 1)) - 1;
      if (is) msk = msk | ((1 << IDepth) - 1);
      if (ds) msk = 31;
      if (m_flush_left > 0) begin
        e.flush = 1'b1;
        e.st    = 2'd2;
        e.stall = 5'd0;
      end else if (m_pending) begin
        e.st    = 2'd1;
        e.stall = 5'h1f;
      end else begin
        e.stall = 5'(msk);
      end
      e.cyc = 4'(m_cyc);
      // Advance the model to the next rising edge.
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (m_pending) begin
        if (!is && !ds) begin
          m_flush_left = FlushLen;
          m_pending    = 0;
        end
      end else if (fr) begin
        if (!is && !ds) m_flush_left = FlushLen;
        else            m_pending    = 1;
      end
      if (clr) m_cyc = 0;
      else if (e.stall != 0 && m_cyc < CntMax) m_cyc++;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare after inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", int'(bus.stall), int'(e.stall));
        chk("flush", int'(bus.flush), int'(e.flush));
        chk("scu_state", int'(bus.scu_state), int'(e.st));
`ifdef SCU_PERF_EN
        chk("stall_cycles", int'(bus.stall_cycles), int'(e.cyc));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    cpu_rst_n     = 1'b0;
    bus.stallreq  = '0;
    bus.i_stall   = 1'b0;
    bus.d_stall   = 1'b0;
    bus.flush_req = 1'b0;
`ifdef SCU_PERF_EN
    bus.perf_clr  = 1'b0;
`endif
    // Reset with noisy inputs: stall must still read zero.
    step(5'b11111, 1, 1, 1, 0, 0);
    step(5'b00000, 0, 0, 0, 0, 0);
    step(5'b00000, 0, 0, 0, 0, 1);
    // Combinational stall mask.
    step(5'b00100, 0, 0, 0, 0, 1);
    step(5'b01010, 0, 0, 0, 0, 1);
    step(5'b00000, 1, 0, 0, 0, 1);
    step(5'b00000, 1, 1, 0, 0, 1);
    step(5'b10000, 0, 0, 0, 0, 1);
    step(5'b00000, 0, 0, 0, 0, 1);
    // Flush with bus idle.
    step(5'b00000, 0, 0, 1, 0, 1);
    step(5'b00001, 0, 0, 0, 0, 1);
    step(5'b00000, 1, 1, 0, 0, 1);
    step(5'b00100, 0, 0, 0, 0, 1);
    // Flush deferred by d_stall, second request merged.
    step(5'b00000, 0, 1, 1, 0, 1);
    step(5'b00000, 0, 1, 0, 0, 1);
    step(5'b00000, 0, 1, 1, 0, 1);
    step(5'b00000, 0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(5'b00000, 0, 0, 0, 0, 1);
    // Reset during the first flush cycle.
    step(5'b00000, 0, 0, 1, 0, 1);
    step(5'b00110, 1, 0, 0, 0, 0);
    step(5'b00000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(5'b00000, 0, 0, 0, 0, 1);
    // Performance counter: 3 stalls, saturation, clear with stall.
    step(5'b00000, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(5'b00001, 0, 0, 0, 0, 1);
    step(5'b00000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(5'b00000, 0, 1, 0, 0, 1);
    step(5'b00000, 0, 0, 0, 0, 1);
    step(5'b00010, 0, 0, 0, 1, 1);
    step(5'b00000, 0, 0, 0, 0, 1);
    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0,
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 20) == 0),
           ($urandom_range(0, 79) != 0));
    end
    step(5'b00000, 0, 0, 0, 0, 1);
    @(negedge clk);
    #2;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scu_ctrl.md
# scu_ctrl

Parametrised stall/flush control unit for the pipelined MIPS core, successor to the fixed 4-bit stall generator.

- Merges per-stage stall requests and AXI instruction/data bus stalls into a per-stage stall vector of configurable depth.
- Sequences exception/branch flushes: a flush is deferred while a bus transaction is outstanding, then held for a programmable number of cycles.
- Sits beside the pipeline registers and drives every stage's stall/flush inputs.

## Interface
Parameters:
- STAGES, 5, number of pipeline stages; stall bit 0 = PC/IF, bit STAGES-1 = last stalled stage.
- I_STALL_DEPTH, 2, number of low stages frozen by i_stall; range 1..STAGES.
- FLUSH_LEN, 2, cycles flush stays high; range 1..15.
- CNT_W, 32, width of the stall performance counter.

Ports:
- cpu_clk_50M  in  1  core clock; all state on rising edge.
- cpu_rst_n  in  1  reset, asynchronous, active-low.
- stallreq  in  STAGES  bit i = stage i requests a stall (`STOP` = 1).
- i_stall  in  1  instruction-side AXI transfer outstanding.
- d_stall  in  1  data-side AXI transfer outstanding.
- flush_req  in  1  one-cycle flush request (exception/eret).
- stall  out  STAGES  per-stage stall, 1 = hold stage.
- flush  out  1  registered flush to all pipeline registers.
- scu_state  out  2  current FSM state (debug).
- stall_cycles  out  CNT_W  only with SCU_PERF_EN.
- perf_clr  in  1  only with SCU_PERF_EN; synchronous clear of stall_cycles.

## Operation
Stall mask, combinational in RUN:
- thermo(k) = bits 0..k set.
- stall = thermo(highest set bit of stallreq) | (i_stall ? thermo(I_STALL_DEPTH-1) : 0) | (d_stall ? all ones : 0).
- stallreq = 0 and no bus stall -> stall = 0.

FSM states (encoding in defines.v): RUN = 2'b00, HOLD = 2'b01, FLUSH = 2'b10.
- RUN, flush_req, i_stall = d_stall = 0: enter FLUSH, load cnt = FLUSH_LEN-1.
- RUN, flush_req, i_stall or d_stall = 1: enter HOLD.
- HOLD: stall = all ones, flush = 0. When i_stall = d_stall = 0, enter FLUSH and load cnt.
- FLUSH: flush = 1, stall = 0 (flush overrides every stall source). cnt == 0 -> RUN, else cnt decrements.
- flush_req in HOLD or FLUSH is merged: ignored, counter not reloaded.
- State value 2'b11 is unreachable. If it is ever reached, the next state is RUN.

Reset:
- While cpu_rst_n = 0: state = RUN, flush = 0, cnt = 0, stall = 0 (forced, independent of inputs), stall_cycles = 0.
- Reset mid-HOLD or mid-FLUSH aborts immediately. The pending flush is discarded.

## Timing
- stall: zero latency from stallreq/i_stall/d_stall in RUN. In HOLD/FLUSH, stall depends on state only.
- flush: registered. The first flush cycle is the cycle after flush_req is sampled with the bus idle, or the cycle after the last bus stall drops in HOLD.
- flush stays high exactly FLUSH_LEN consecutive cycles. RUN resumes in the following cycle, and stall follows its inputs again that cycle.
- A bus stall rising during FLUSH does not extend or abort the flush. Bus stall takes effect in RUN.

## Configuration
- SCU_PERF_EN defined:
  - Adds stall_cycles and perf_clr.
  - Counter increments each cycle stall != 0 (including HOLD) and saturates at 2^CNT_W-1.
  - perf_clr has priority over increment.
- SCU_PERF_EN undefined: both ports and the counter are absent. Stall/flush behaviour is identical.

## Structure
- Shared header defines.v holds:
  - `STOP` / `NOSTOP`.
  - FSM codes SCU_RUN, SCU_HOLD, SCU_FLUSH.
  - The `STALL_BUS` width derived from STAGES.
- Sub-module stall_mask_gen (parameter STAGES): priority encoder plus thermometer expansion. It is instantiated once for stallreq. The fixed i_stall/d_stall masks are constants.
- FSM, flush counter and perf counter live in scu_ctrl.

## Test plan
All scenarios use STAGES = 5, I_STALL_DEPTH = 2, FLUSH_LEN = 2.
- stallreq = 5'b00100, bus idle -> stall = 5'b00111 the same cycle. stallreq = 5'b01010 -> stall = 5'b01111.
- i_stall = 1, stallreq = 0 -> stall = 5'b00011. Adding d_stall = 1 -> stall = 5'b11111.
- flush_req pulse at cycle 0, bus idle -> flush = 1 in cycles 1–2, stall = 0 in cycles 1–2, scu_state = RUN at cycle 3.
- flush_req while d_stall = 1 for 3 more cycles -> HOLD, stall = 5'b11111, flush = 0. flush = 1 for 2 cycles starting the cycle after d_stall falls. A second flush_req during HOLD causes no extra flush cycles.
- cpu_rst_n low during the first FLUSH cycle -> flush = 0, stall = 0 immediately. After release, scu_state = RUN and no flush occurs.
- SCU_PERF_EN, CNT_W = 4:
  - 3 stalled cycles -> stall_cycles = 3.
  - 20 stalled cycles -> stall_cycles holds at 15.
  - perf_clr together with a stall -> stall_cycles = 0 next cycle.
